// File: rtl/ring_nic_pkg.sv
// Shared definitions for the ring NIC: packet field positions and the
// processor-visible register address codes.
package ring_nic_pkg;

  localparam int W = 64;

  // Packet layout. The NIC itself only looks at the virtual-channel bit.
  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;  // 0 = clockwise, 1 = counter-clockwise
  localparam int HOP_HI  = 55;
  localparam int HOP_LO  = 48;
  localparam int SRC_HI  = 47;
  localparam int SRC_LO  = 32;
  localparam int PAY_HI  = 31;
  localparam int PAY_LO  = 0;

  // Processor register select codes.
  typedef enum logic [1:0] {
    ADDR_IN_BUF   = 2'b00,  // read: received packet
    ADDR_IN_STAT  = 2'b01,  // read: {63'b0, in_full}
    ADDR_OUT_BUF  = 2'b10,  // write: packet to send
    ADDR_OUT_STAT = 2'b11   // read: {63'b0, out_full}
  } nic_addr_e;

  // Virtual channel a packet travels on.
  function automatic logic pkt_vc(input logic [W-1:0] pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

// File: rtl/ring_nic_slot.sv
// One-entry packet register with a full flag. Load has priority over
// clear, so a packet arriving in the same cycle the slot is drained is
// kept rather than lost.
module ring_nic_slot
  import ring_nic_pkg::*;
(
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_clear,
  output logic [W-1:0] o_data,
  output logic         o_full
);

  logic [W-1:0] r_data;
  logic         r_full;

  // Data/flag register: synchronous active-low reset, then load, then clear.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/ring_nic.sv
// Ring network interface: one receive slot and one transmit slot between
// a processor register port and a router PE port.
//
// Handshakes (both directions): a transfer happens at a rising edge where
// the sender's valid (net_si / net_so) and the receiver's ready
// (net_ri / net_ro) are both 1. Valid never depends on the same-cycle
// state of the other side's valid; both are forced low while reset is low.
// The transmit side only asserts net_so when the held packet's VC bit
// matches the current ring polarity.
module ring_nic
  import ring_nic_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         polarity,
  input  logic [1:0]   addr,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out,
  input  logic         nicEn,
  input  logic         nicWrEn,
  output logic         net_so,
  input  logic         net_ro,
  output logic [W-1:0] net_do,
  input  logic         net_si,
  output logic         net_ri,
  input  logic [W-1:0] net_di
);

  logic         w_rd;
  logic         w_wr;
  logic         w_in_full;
  logic [W-1:0] w_in_data;
  logic         w_out_full;
  logic [W-1:0] w_out_data;
  logic         w_in_load;
  logic         w_in_clear;
  logic         w_out_load;
  logic         w_out_clear;

  assign w_rd = nicEn & ~nicWrEn;
  assign w_wr = nicEn & nicWrEn;

  // Router-facing handshake outputs, held low during reset.
  assign net_ri = reset & ~w_in_full;
  assign net_so = reset & w_out_full & net_ro & (pkt_vc(w_out_data) == polarity);
  assign net_do = w_out_data;

  assign w_in_load   = net_si & net_ri;
  assign w_in_clear  = w_rd & (addr == ADDR_IN_BUF);
  assign w_out_load  = w_wr & (addr == ADDR_OUT_BUF) & ~w_out_full;
  assign w_out_clear = net_so;

  ring_nic_slot u_in_slot (
    .clk     (clk),
    .i_rst_n (reset),
    .i_load  (w_in_load),
    .i_data  (net_di),
    .i_clear (w_in_clear),
    .o_data  (w_in_data),
    .o_full  (w_in_full)
  );

  ring_nic_slot u_out_slot (
    .clk     (clk),
    .i_rst_n (reset),
    .i_load  (w_out_load),
    .i_data  (d_in),
    .i_clear (w_out_clear),
    .o_data  (w_out_data),
    .o_full  (w_out_full)
  );

  // Processor read mux; zero unless a read of a readable register.
  always_comb begin
    d_out = '0;
    if (w_rd) begin
      case (addr)
        ADDR_IN_BUF:   d_out = w_in_data;
        ADDR_IN_STAT:  d_out = {{(W-1){1'b0}}, w_in_full};
        ADDR_OUT_STAT: d_out = {{(W-1){1'b0}}, w_out_full};
        default:       d_out = '0;
      endcase
    end
  end

endmodule

// File: doc/ring_nic.md
RING_NIC -- requirements
Module: ring_nic

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low reset.
REQ-003 SHALL have: polarity  in  1  ring virtual-channel phase, same signal the router receives.
REQ-004 SHALL have: addr  in  2  processor register select.
REQ-005 SHALL have: d_in  in  64  processor write data.
REQ-006 SHALL have: d_out  out  64  processor read data.
REQ-007 SHALL have: nicEn  in  1  processor access enable.
REQ-008 SHALL have: nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn).
REQ-009 SHALL have: net_so  out  1  send to router PE input (router pesi).
REQ-010 SHALL have: net_ro  in  1  router PE input ready (router peri).
REQ-011 SHALL have: net_do  out  64  packet to router (router pedi).
REQ-012 SHALL have: net_si  in  1  send from router PE output (router peso).
REQ-013 SHALL have: net_ri  out  1  NIC ready to accept (router pero).
REQ-014 SHALL have: net_di  in  64  packet from router (router pedo).

Function
REQ-015 Packet format SHALL be: [63] vc, [62] dir (0 = cw, 1 = ccw), [61:56] reserved, [55:48] hop, [47:32] source, [31:0] payload; the NIC interprets only vc.
REQ-016 Address map SHALL be: 00 input buffer (read), 01 input status (read), 10 output buffer (write), 11 output status (read).
REQ-017 Input side SHALL be a one-entry 64-bit buffer with flag in_full.
REQ-018 net_ri SHALL equal ~in_full.
REQ-019 When net_si=1 and net_ri=1 at an edge, the buffer SHALL capture net_di and set in_full.
REQ-020 A processor read of addr 00 (nicEn=1, nicWrEn=0) SHALL return the buffer on d_out combinationally and clear in_full at that edge; net_ri SHALL rise the following cycle.
REQ-021 Reading addr 00 while in_full=0 SHALL return the stale buffer contents and leave in_full=0.
REQ-022 Output side SHALL be a one-entry 64-bit buffer with flag out_full.
REQ-023 A write to addr 10 when out_full=0 SHALL capture d_in and set out_full; a write when out_full=1 SHALL be dropped without side effect.
REQ-024 net_so SHALL equal out_full AND net_ro AND (out_buf[63] == polarity).
REQ-025 net_do SHALL always drive out_buf.
REQ-026 At any edge where net_so=1, the router takes the packet and out_full SHALL clear; the next write is accepted at the following edge at the earliest.
REQ-027 If out_full=1 and net_ro=0 or vc≠polarity, the packet SHALL be held indefinitely.
REQ-028 Status reads SHALL return {63'b0, in_full} for addr 01 and {63'b0, out_full} for addr 11.
REQ-029 d_out SHALL be 0 when nicEn=0, on a write cycle, and on a read of addr 10.
REQ-030 Writes to addr 00, 01, and 11 SHALL be ignored.
REQ-031 Input and output sides SHALL operate independently, with simultaneous receive, send, read, and write in one cycle allowed.

Reset
REQ-032 While reset=0 at an edge, in_full, out_full, and both buffers SHALL clear to 0.
REQ-033 While reset is asserted, net_so and net_ri SHALL be forced to 0.
REQ-034 Reset mid-transfer SHALL discard buffered packets, with no transfer at that edge.
REQ-035 After reset, net_ri=1 and net_so=0.

Structure
REQ-036 A shared package SHALL hold the packet field positions (VC_BIT, DIR_BIT, HOP range, SRC range, PAYLOAD range) and the four address codes.
REQ-037 One sub-module, ring_nic_slot, SHALL implement the one-entry 64-bit register with full flag, load and clear, and be instantiated once per direction.

Verification
REQ-038 Inject: reset, then net_si=1 with net_di=64'h0000_0100_0001_CAFE -> captured in 1 edge, net_ri=0, addr 01 reads 1; read addr 00 returns 64'h0000_0100_0001_CAFE, and net_ri=1 the next cycle.
REQ-039 Send: write addr 10 with d_in=64'h8000_0000_0002_BEEF, net_ro=1, polarity toggling -> net_so=1 only in a polarity=1 cycle; out_full=0 after that edge; net_do equals the packet.
REQ-040 Backpressure: out_full=1, net_ro=0 for 10 cycles -> net_so stays 0; a second write of 64'h1 is dropped; after net_ro=1, the original packet is sent.
REQ-041 Concurrency: in one cycle, net_si=1 (in empty), net_so transfer, and a processor write to addr 10 (out_full=0 before the edge not true) -> receive completes, send completes, and the write is dropped; a repeated write the next cycle succeeds.
REQ-042 Reset mid-op: both buffers full, reset=0 for 1 edge -> addr 01 and 11 read 0, net_so=0 during reset, net_ri=1 after release.
